// File: rtl/sid_audio_decim.sv
// SID output stage: boxcar decimator, optional one-pole DC blocker, 16-bit saturation
// and a small output FIFO with valid/ready handshake and sticky overflow flag.
module sid_audio_decim #(
   parameter int unsigned DECIM_LOG2 = 4,
   parameter int unsigned DCB_SHIFT  = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             ce,
   input  logic signed [17:0]               audio_in,
   input  logic                             dc_en,
   input  logic                             ovf_clr,
   output logic signed [15:0]               out_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic                             overflow,
   output logic [$clog2(FIFO_DEPTH):0]      level
);

   localparam int unsigned AW = 18 + DECIM_LOG2;
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = PW + 1;

   logic signed [AW-1:0]       r_acc;
   logic [DECIM_LOG2-1:0]      r_cnt;
   logic signed [17:0]         r_avg;
   logic                       r_avg_v;
   logic signed [17:0]         r_x_prev;
   logic signed [19:0]         r_y_prev;
   logic signed [19:0]         r_y;
   logic                       r_y_v;
   logic signed [15:0]         r_mem [FIFO_DEPTH];
   logic [PW-1:0]              r_wr;
   logic [PW-1:0]              r_rd;
   logic [LW-1:0]              r_level;
   logic                       r_ovf;

   logic signed [AW-1:0]       w_sum;
   logic signed [19:0]         w_ysh;
   logic signed [21:0]         w_dc_sum;
   logic signed [19:0]         w_dc_sat;
   logic signed [19:0]         w_y;
   logic signed [15:0]         w_s16;
   logic                       w_full;
   logic                       w_pop;
   logic                       w_push;
   logic                       w_wr_en;

   assign w_sum = r_acc + {{DECIM_LOG2{audio_in[17]}}, audio_in};

   // Wide intermediate so the 20-bit clamp sees the true sum
   assign w_ysh    = r_y_prev >>> DCB_SHIFT;
   assign w_dc_sum = {{4{r_avg[17]}}, r_avg} - {{4{r_x_prev[17]}}, r_x_prev}
                   + {{2{r_y_prev[19]}}, r_y_prev} - {{2{w_ysh[19]}}, w_ysh};

   always_comb begin
      w_dc_sat = w_dc_sum[19:0];
      if (w_dc_sum[21:19] != 3'b000 && w_dc_sum[21:19] != 3'b111) begin
         w_dc_sat = w_dc_sum[21] ? 20'sh80000 : 20'sh7FFFF;
      end
      w_y = dc_en ? w_dc_sat : {{2{r_avg[17]}}, r_avg};
   end

   // s16 = clamp16(y >>> 2): y[19:2] is 18 bits, saturate when top 3 bits disagree
   always_comb begin
      w_s16 = r_y[17:2];
      if (r_y[19:17] != 3'b000 && r_y[19:17] != 3'b111) begin
         w_s16 = r_y[19] ? 16'sh8000 : 16'sh7FFF;
      end
   end

   assign w_full  = (r_level == LW'(FIFO_DEPTH));
   assign w_pop   = (r_level != '0) && out_ready;
   assign w_push  = r_y_v;
   assign w_wr_en = w_push && (!w_full || w_pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_acc    <= '0;
         r_cnt    <= '0;
         r_avg    <= '0;
         r_avg_v  <= 1'b0;
         r_x_prev <= '0;
         r_y_prev <= '0;
         r_y      <= '0;
         r_y_v    <= 1'b0;
         r_wr     <= '0;
         r_rd     <= '0;
         r_level  <= '0;
         r_ovf    <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      end else begin
         r_avg_v <= 1'b0;
         if (ce) begin
            if (&r_cnt) begin
               r_avg   <= w_sum[AW-1:DECIM_LOG2];
               r_avg_v <= 1'b1;
               r_acc   <= '0;
               r_cnt   <= '0;
            end else begin
               r_acc <= w_sum;
               r_cnt <= r_cnt + DECIM_LOG2'(1);
            end
         end

         r_y_v <= r_avg_v;
         if (r_avg_v) begin
            r_x_prev <= r_avg;
            r_y_prev <= dc_en ? w_y : '0;
            r_y      <= w_y;
         end

         if (w_wr_en) begin
            r_mem[r_wr] <= w_s16;
            r_wr        <= r_wr + PW'(1);
         end
         if (w_pop) r_rd <= r_rd + PW'(1);
         if (w_wr_en && !w_pop)      r_level <= r_level + LW'(1);
         else if (!w_wr_en && w_pop) r_level <= r_level - LW'(1);

         if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
         else if (ovf_clr)               r_ovf <= 1'b0;
      end
   end

   assign out_data  = r_mem[r_rd];
   assign out_valid = (r_level != '0);
   assign overflow  = r_ovf;
   assign level     = r_level;

endmodule
